// File: rtl/image_pkg.sv
// Shared types and constants for the ROI cropping pipeline: window geometry record,
// decimation encoding and small sizing helpers.
package image_pkg;

  // Widest supported H/V address; module parameters must not exceed these.
  localparam int unsigned HMaxW = 16;
  localparam int unsigned VMaxW = 16;

  localparam logic [1:0] DecOne     = 2'd0;
  localparam logic [1:0] DecHalf    = 2'd1;
  localparam logic [1:0] DecQuarter = 2'd2;
  localparam logic [1:0] DecEighth  = 2'd3;

  typedef struct packed {
    logic [HMaxW-1:0] x0;
    logic [VMaxW-1:0] y0;
    logic [HMaxW-1:0] w;
    logic [VMaxW-1:0] h;
    logic [1:0]       dec;
  } roi_cfg_t;

  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Low offset bits that must be zero for a pixel to survive decimation.
  function automatic logic [7:0] dec_mask(input logic [1:0] dec);
    logic [7:0] m;
    unique case (dec)
      DecOne:     m = 8'h00;
      DecHalf:    m = 8'h01;
      DecQuarter: m = 8'h03;
      DecEighth:  m = 8'h07;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/roi_window_unit.sv
// One crop window: double-buffered geometry, hit/decimation compare (stage 1) and the
// per-window address counter, DONE pulse and sticky overflow (stage 2).
module roi_window_unit
  import image_pkg::*;
#(
  parameter int unsigned H_ADDR_WIDTH   = 11,
  parameter int unsigned V_ADDR_WIDTH   = 10,
  parameter int unsigned OUT_ADDR_WIDTH = 11
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      frame_start_i,
  input  logic                      pix_valid_i,
  input  logic [H_ADDR_WIDTH-1:0]   addr_h_i,
  input  logic [V_ADDR_WIDTH-1:0]   addr_v_i,
  input  logic                      cfg_we_i,
  input  roi_cfg_t                  cfg_i,
  output logic                      hit_o,
  output logic [OUT_ADDR_WIDTH-1:0] addr_o,
  output logic                      done_o,
  output logic                      ovf_o
);

  localparam int unsigned HW = HMaxW + 1;
  localparam int unsigned VW = VMaxW + 1;

  roi_cfg_t shadow_q, active_q, cfg_eff;

  logic                      hit_q, last_q, fs_q;
  logic [OUT_ADDR_WIDTH-1:0] cnt_q, cnt_d, cnt_base;
  logic                      flag_q, flag_d, flag_base;
  logic                      done_q, done_d;
  logic                      ovf_q, ovf_d, ovf_base;

  logic [7:0]    mask;
  logic [HW-1:0] ah, x0e, xend, dh, xlast;
  logic [VW-1:0] av, y0e, yend, dv, ylast;
  logic          in_x, in_y, hit, is_last;

  // The frame-start pixel already belongs to the new frame, so it sees the shadow geometry.
  always_comb begin
    cfg_eff = frame_start_i ? shadow_q : active_q;
    mask    = dec_mask(cfg_eff.dec);

    ah    = HW'(addr_h_i);
    x0e   = HW'(cfg_eff.x0);
    xend  = x0e + HW'(cfg_eff.w);
    dh    = ah - x0e;
    xlast = (HW'(cfg_eff.w) - HW'(1)) & ~HW'(mask);

    av    = VW'(addr_v_i);
    y0e   = VW'(cfg_eff.y0);
    yend  = y0e + VW'(cfg_eff.h);
    dv    = av - y0e;
    ylast = (VW'(cfg_eff.h) - VW'(1)) & ~VW'(mask);

    in_x    = (ah >= x0e) && (ah < xend) && ((dh[7:0] & mask) == 8'h00);
    in_y    = (av >= y0e) && (av < yend) && ((dv[7:0] & mask) == 8'h00);
    hit     = pix_valid_i && in_x && in_y;
    is_last = (dh == xlast) && (dv == ylast);
  end

  // fs_q marks the first pixel of a frame in stage 1; per-frame state restarts there.
  always_comb begin
    cnt_base  = fs_q ? '0 : cnt_q;
    flag_base = fs_q ? 1'b0 : flag_q;
    ovf_base  = fs_q ? 1'b0 : ovf_q;

    cnt_d  = cnt_base + OUT_ADDR_WIDTH'(hit_q);
    done_d = hit_q && last_q && !flag_base;
    flag_d = flag_base || done_d;
    ovf_d  = ovf_base || (hit_q && (cnt_base == '1));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shadow_q <= '0;
      active_q <= '0;
      hit_q    <= 1'b0;
      last_q   <= 1'b0;
      fs_q     <= 1'b0;
      cnt_q    <= '0;
      flag_q   <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      if (cfg_we_i) begin
        shadow_q <= cfg_i;
      end
      if (frame_start_i) begin
        active_q <= shadow_q;
      end
      hit_q  <= hit;
      last_q <= is_last;
      fs_q   <= frame_start_i;
      cnt_q  <= cnt_d;
      flag_q <= flag_d;
      done_q <= done_d;
      ovf_q  <= ovf_d;
    end
  end

  assign hit_o  = hit_q;
  assign addr_o = cnt_base;
  assign done_o = done_q;
  assign ovf_o  = ovf_q;

endmodule

// File: rtl/roi_multi_cropper.sv
// Multi-window raster cropper: N_ROI window units feed a lowest-index-wins mux into a single
// write stream with two cycles of latency.
module roi_multi_cropper
  import image_pkg::*;
#(
  parameter int unsigned N_ROI          = 2,
  parameter int unsigned H_ADDR_WIDTH   = 11,
  parameter int unsigned V_ADDR_WIDTH   = 10,
  parameter int unsigned OUT_ADDR_WIDTH = 11,
  parameter int unsigned DATA_WIDTH     = 16
) (
  input  logic                           CLK,
  input  logic                           RESET,
  input  logic                           FRAME_START,
  input  logic                           PIX_VALID,
  input  logic [H_ADDR_WIDTH-1:0]        ADDR_H,
  input  logic [V_ADDR_WIDTH-1:0]        ADDR_V,
  input  logic [DATA_WIDTH-1:0]          PIX_DATA,
  input  logic                           CFG_WE,
  input  logic [sel_width(N_ROI)-1:0]    CFG_SEL,
  input  logic [H_ADDR_WIDTH-1:0]        CFG_X0,
  input  logic [H_ADDR_WIDTH-1:0]        CFG_W,
  input  logic [V_ADDR_WIDTH-1:0]        CFG_Y0,
  input  logic [V_ADDR_WIDTH-1:0]        CFG_H,
  input  logic [1:0]                     CFG_DEC,
  output logic                           OUT_DATA_VALID,
  output logic [sel_width(N_ROI)-1:0]    OUT_ROI,
  output logic [OUT_ADDR_WIDTH-1:0]      OUT_DATA_ADDR,
  output logic [DATA_WIDTH-1:0]          OUT_DATA,
  output logic [N_ROI-1:0]               OUT_ROI_DONE,
  output logic [N_ROI-1:0]               OUT_OVERFLOW
);

  localparam int unsigned SelW = sel_width(N_ROI);

  roi_cfg_t cfg_in;

  logic [N_ROI-1:0]          win_hit, win_done, win_ovf;
  logic [OUT_ADDR_WIDTH-1:0] win_addr [N_ROI];

  logic                      sel_valid;
  logic [SelW-1:0]           sel_idx;
  logic [OUT_ADDR_WIDTH-1:0] sel_addr;

  logic [DATA_WIDTH-1:0]     data_q;
  logic                      valid_q;
  logic [SelW-1:0]           roi_q;
  logic [OUT_ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0]     out_data_q;

  assign cfg_in = '{
    x0:  HMaxW'(CFG_X0),
    y0:  VMaxW'(CFG_Y0),
    w:   HMaxW'(CFG_W),
    h:   VMaxW'(CFG_H),
    dec: CFG_DEC
  };

  for (genvar k = 0; k < N_ROI; k++) begin : g_win
    roi_window_unit #(
      .H_ADDR_WIDTH   (H_ADDR_WIDTH),
      .V_ADDR_WIDTH   (V_ADDR_WIDTH),
      .OUT_ADDR_WIDTH (OUT_ADDR_WIDTH)
    ) u_win (
      .clk_i         (CLK),
      .rst_i         (RESET),
      .frame_start_i (FRAME_START),
      .pix_valid_i   (PIX_VALID),
      .addr_h_i      (ADDR_H),
      .addr_v_i      (ADDR_V),
      .cfg_we_i      (CFG_WE && (CFG_SEL == SelW'(k))),
      .cfg_i         (cfg_in),
      .hit_o         (win_hit[k]),
      .addr_o        (win_addr[k]),
      .done_o        (win_done[k]),
      .ovf_o         (win_ovf[k])
    );
  end

  // Scan from the top index down so the lowest hitting window is the last to assign.
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    sel_addr  = '0;
    for (int k = N_ROI - 1; k >= 0; k--) begin
      if (win_hit[k]) begin
        sel_valid = 1'b1;
        sel_idx   = SelW'(k);
        sel_addr  = win_addr[k];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      data_q     <= '0;
      valid_q    <= 1'b0;
      roi_q      <= '0;
      addr_q     <= '0;
      out_data_q <= '0;
    end else begin
      data_q     <= PIX_DATA;
      valid_q    <= sel_valid;
      roi_q      <= sel_idx;
      addr_q     <= sel_addr;
      out_data_q <= data_q;
    end
  end

  assign OUT_DATA_VALID = valid_q;
  assign OUT_ROI        = roi_q;
  assign OUT_DATA_ADDR  = addr_q;
  assign OUT_DATA       = out_data_q;
  assign OUT_ROI_DONE   = win_done;
  assign OUT_OVERFLOW   = win_ovf;

endmodule

// File: tb/tb_roi_multi_cropper.sv
// Directed bench for roi_multi_cropper: a 2-window instance plus a 1-window instance with a
// 4-bit output address, both fed from the same raster and configuration bus.
module tb_roi_multi_cropper;

  typedef struct {
    logic        roi;
    logic [10:0] addr;
    logic [15:0] data;
  } ent_t;

  logic        clk;
  logic        rst;
  logic        fs;
  logic        pv;
  logic [10:0] ah;
  logic [9:0]  av;
  logic [15:0] pd;
  logic        cfg_we;
  logic        csel;
  logic [10:0] cx0, cw;
  logic [9:0]  cy0, ch;
  logic [1:0]  cdec;

  logic        ov;
  logic        oroi;
  logic [10:0] oaddr;
  logic [15:0] odata;
  logic [1:0]  odone, oovf;

  logic        ov4;
  logic        oroi4;
  logic [3:0]  oaddr4;
  logic [15:0] odata4;
  logic        odone4, oovf4;

  ent_t        log_q[$];
  logic [3:0]  log4[$];
  int          done_cnt[2];
  logic [15:0] done_pix[2];
  logic [10:0] done_addr[2];
  int          done4_cnt;

  int errors = 0;
  int checks = 0;

  roi_multi_cropper #(
    .N_ROI(2), .H_ADDR_WIDTH(11), .V_ADDR_WIDTH(10), .OUT_ADDR_WIDTH(11), .DATA_WIDTH(16)
  ) dut (
    .CLK(clk), .RESET(rst), .FRAME_START(fs), .PIX_VALID(pv), .ADDR_H(ah), .ADDR_V(av),
    .PIX_DATA(pd), .CFG_WE(cfg_we), .CFG_SEL(csel), .CFG_X0(cx0), .CFG_W(cw), .CFG_Y0(cy0),
    .CFG_H(ch), .CFG_DEC(cdec), .OUT_DATA_VALID(ov), .OUT_ROI(oroi), .OUT_DATA_ADDR(oaddr),
    .OUT_DATA(odata), .OUT_ROI_DONE(odone), .OUT_OVERFLOW(oovf)
  );

  roi_multi_cropper #(
    .N_ROI(1), .H_ADDR_WIDTH(11), .V_ADDR_WIDTH(10), .OUT_ADDR_WIDTH(4), .DATA_WIDTH(16)
  ) dut4 (
    .CLK(clk), .RESET(rst), .FRAME_START(fs), .PIX_VALID(pv), .ADDR_H(ah), .ADDR_V(av),
    .PIX_DATA(pd), .CFG_WE(cfg_we), .CFG_SEL(csel), .CFG_X0(cx0), .CFG_W(cw), .CFG_Y0(cy0),
    .CFG_H(ch), .CFG_DEC(cdec), .OUT_DATA_VALID(ov4), .OUT_ROI(oroi4), .OUT_DATA_ADDR(oaddr4),
    .OUT_DATA(odata4), .OUT_ROI_DONE(odone4), .OUT_OVERFLOW(oovf4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ov) log_q.push_back('{roi: oroi, addr: oaddr, data: odata});
    for (int k = 0; k < 2; k++) begin
      if (odone[k]) begin
        done_cnt[k]++;
        done_pix[k]  = odata;
        done_addr[k] = oaddr;
      end
    end
    if (ov4) log4.push_back(oaddr4);
    if (odone4) done4_cnt++;
  end

  task automatic clear_log();
    log_q.delete();
    log4.delete();
    done_cnt[0] = 0;
    done_cnt[1] = 0;
    done_pix[0] = '0;
    done_pix[1] = '0;
    done_addr[0] = '0;
    done_addr[1] = '0;
    done4_cnt = 0;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic sel, input int x0, input int y0, input int w, input int h,
                     input int dec);
    csel = sel;
    cx0 = 11'(x0);
    cy0 = 10'(y0);
    cw = 11'(w);
    ch = 10'(h);
    cdec = 2'(dec);
    cfg_we = 1'b1;
    cycle();
    cfg_we = 1'b0;
  endtask

  // Streams a cols x rows raster from (0,0); pixel data encodes {row, col}.
  task automatic run_frame(input int cols, input int rows, input int we_at);
    int idx = 0;
    for (int v = 0; v < rows; v++) begin
      for (int h = 0; h < cols; h++) begin
        fs = (idx == 0);
        pv = 1'b1;
        ah = 11'(h);
        av = 10'(v);
        pd = {8'(v), 8'(h)};
        cfg_we = (idx == we_at);
        cycle();
        idx++;
      end
    end
    fs = 1'b0;
    pv = 1'b0;
    cfg_we = 1'b0;
    repeat (4) cycle();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) cycle();
    checks++; if (ov !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", ov); end
    checks++; if (oroi !== 1'b0) begin errors++; $display("FAIL reset_roi: got %b want 0", oroi); end
    checks++; if (oaddr !== 11'd0) begin errors++; $display("FAIL reset_addr: got %0d want 0", oaddr); end
    checks++; if (odata !== 16'd0) begin errors++; $display("FAIL reset_data: got %h want 0", odata); end
    checks++; if (odone !== 2'b00) begin errors++; $display("FAIL reset_done: got %b want 00", odone); end
    checks++; if (oovf !== 2'b00) begin errors++; $display("FAIL reset_ovf: got %b want 00", oovf); end
    checks++; if (ov4 !== 1'b0) begin errors++; $display("FAIL reset_valid4: got %b want 0", ov4); end
    rst = 1'b0;
    cycle();
    clear_log();
    run_frame(12, 8, -1);
    checks++;
    if (log_q.size() !== 0) begin
      errors++; $display("FAIL reset_no_cfg_strobes: got %0d want 0", log_q.size());
    end
  endtask

  task automatic test_single();
    cfg(1'b1, 0, 0, 0, 0, 0);
    cfg(1'b0, 10, 5, 4, 2, 0);
    clear_log();
    run_frame(20, 8, -1);
    checks++;
    if (log_q.size() !== 8) begin errors++; $display("FAIL single_count: got %0d want 8", log_q.size()); end
    for (int i = 0; i < 8 && i < log_q.size(); i++) begin
      logic [15:0] want;
      want = {8'(5 + i / 4), 8'(10 + i % 4)};
      checks++;
      if (log_q[i].addr !== 11'(i) || log_q[i].roi !== 1'b0 || log_q[i].data !== want) begin
        errors++;
        $display("FAIL single_strobe%0d: got roi=%b addr=%0d data=%h want roi=0 addr=%0d data=%h",
                 i, log_q[i].roi, log_q[i].addr, log_q[i].data, i, want);
      end
    end
    checks++; if (done_cnt[0] !== 1) begin errors++; $display("FAIL single_done_cnt: got %0d want 1", done_cnt[0]); end
    checks++; if (done_pix[0] !== 16'h060D) begin errors++; $display("FAIL single_done_pix: got %h want 060d", done_pix[0]); end
    checks++; if (done_cnt[1] !== 0) begin errors++; $display("FAIL single_done1_cnt: got %0d want 0", done_cnt[1]); end
    // Latency: one pixel at (10,5) must appear after exactly two edges.
    pv = 1'b1; ah = 11'd10; av = 10'd5; pd = 16'h050A;
    cycle();
    pv = 1'b0;
    checks++; if (ov !== 1'b0) begin errors++; $display("FAIL latency_1cyc: got %b want 0", ov); end
    cycle();
    checks++; if (ov !== 1'b1) begin errors++; $display("FAIL latency_2cyc: got %b want 1", ov); end
    checks++; if (odata !== 16'h050A) begin errors++; $display("FAIL latency_data: got %h want 050a", odata); end
    repeat (3) cycle();
  endtask

  task automatic test_decimation();
    cfg(1'b0, 10, 5, 4, 2, 1);
    clear_log();
    run_frame(20, 8, -1);
    checks++;
    if (log_q.size() !== 2) begin errors++; $display("FAIL dec_count: got %0d want 2", log_q.size()); end
    if (log_q.size() >= 2) begin
      checks++;
      if (log_q[0].addr !== 11'd0 || log_q[0].data !== 16'h050A) begin
        errors++; $display("FAIL dec_first: got addr=%0d data=%h want 0 050a", log_q[0].addr, log_q[0].data);
      end
      checks++;
      if (log_q[1].addr !== 11'd1 || log_q[1].data !== 16'h050C) begin
        errors++; $display("FAIL dec_second: got addr=%0d data=%h want 1 050c", log_q[1].addr, log_q[1].data);
      end
    end
    checks++; if (done_cnt[0] !== 1) begin errors++; $display("FAIL dec_done_cnt: got %0d want 1", done_cnt[0]); end
    checks++; if (done_pix[0] !== 16'h050C) begin errors++; $display("FAIL dec_done_pix: got %h want 050c", done_pix[0]); end
  endtask

  task automatic test_overlap();
    int c0 = 0;
    int c1 = 0;
    int n = 0;
    cfg(1'b0, 0, 0, 8, 8, 0);
    cfg(1'b1, 4, 4, 8, 8, 0);
    clear_log();
    run_frame(16, 14, -1);
    for (int v = 0; v < 14; v++) begin
      for (int h = 0; h < 16; h++) begin
        logic in0, in1;
        in0 = (h < 8) && (v < 8);
        in1 = (h >= 4) && (h < 12) && (v >= 4) && (v < 12);
        if ((in0 || in1) && n < log_q.size()) begin
          logic        wroi;
          logic [10:0] waddr;
          wroi  = in0 ? 1'b0 : 1'b1;
          waddr = in0 ? 11'(c0) : 11'(c1);
          checks++;
          if (log_q[n].roi !== wroi || log_q[n].addr !== waddr || log_q[n].data !== {8'(v), 8'(h)}) begin
            errors++;
            $display("FAIL overlap_px(%0d,%0d): got roi=%b addr=%0d want roi=%b addr=%0d",
                     h, v, log_q[n].roi, log_q[n].addr, wroi, waddr);
          end
        end
        if (in0 || in1) n++;
        if (in0) c0++;
        if (in1) c1++;
      end
    end
    checks++; if (log_q.size() !== 112) begin errors++; $display("FAIL overlap_count: got %0d want 112", log_q.size()); end
    checks++; if (done_cnt[1] !== 1) begin errors++; $display("FAIL overlap_done1_cnt: got %0d want 1", done_cnt[1]); end
    checks++; if (done_pix[1] !== 16'h0B0B) begin errors++; $display("FAIL overlap_done1_pix: got %h want 0b0b", done_pix[1]); end
    checks++; if (done_addr[1] !== 11'd63) begin errors++; $display("FAIL overlap_done1_addr: got %0d want 63", done_addr[1]); end
    checks++; if (done_pix[0] !== 16'h0707) begin errors++; $display("FAIL overlap_done0_pix: got %h want 0707", done_pix[0]); end
  endtask

  task automatic test_shadow();
    logic [15:0] got;
    cfg(1'b1, 0, 0, 0, 0, 0);
    cfg(1'b0, 10, 5, 4, 2, 0);
    run_frame(20, 8, -1);
    // Mid-frame write to X0=2,Y0=1: this frame keeps the old geometry.
    cx0 = 11'd2; cy0 = 10'd1;
    clear_log();
    run_frame(20, 8, 30);
    got = (log_q.size() > 0) ? log_q[0].data : 16'hxxxx;
    checks++; if (log_q.size() !== 8) begin errors++; $display("FAIL shadow_mid_count: got %0d want 8", log_q.size()); end
    checks++; if (got !== 16'h050A) begin errors++; $display("FAIL shadow_mid_first: got %h want 050a", got); end
    // Write coincident with frame start: the earlier shadow applies now.
    cx0 = 11'd6; ch = 10'd1;
    clear_log();
    run_frame(20, 8, 0);
    got = (log_q.size() > 0) ? log_q[0].data : 16'hxxxx;
    checks++; if (log_q.size() !== 8) begin errors++; $display("FAIL shadow_fs_count: got %0d want 8", log_q.size()); end
    checks++; if (got !== 16'h0102) begin errors++; $display("FAIL shadow_fs_first: got %h want 0102", got); end
    clear_log();
    run_frame(20, 8, -1);
    got = (log_q.size() > 0) ? log_q[0].data : 16'hxxxx;
    checks++; if (log_q.size() !== 4) begin errors++; $display("FAIL shadow_next_count: got %0d want 4", log_q.size()); end
    checks++; if (got !== 16'h0106) begin errors++; $display("FAIL shadow_next_first: got %h want 0106", got); end
  endtask

  task automatic test_overflow();
    logic [3:0] a15, a16, a24;
    cfg(1'b1, 0, 0, 0, 0, 0);
    cfg(1'b0, 2, 2, 5, 5, 0);
    clear_log();
    run_frame(10, 9, -1);
    a15 = (log4.size() > 15) ? log4[15] : 4'hx;
    a16 = (log4.size() > 16) ? log4[16] : 4'hx;
    a24 = (log4.size() > 24) ? log4[24] : 4'hx;
    checks++; if (log4.size() !== 25) begin errors++; $display("FAIL ovf_count: got %0d want 25", log4.size()); end
    checks++; if (a15 !== 4'd15) begin errors++; $display("FAIL ovf_addr15: got %0d want 15", a15); end
    checks++; if (a16 !== 4'd0) begin errors++; $display("FAIL ovf_wrap: got %0d want 0", a16); end
    checks++; if (a24 !== 4'd8) begin errors++; $display("FAIL ovf_addr24: got %0d want 8", a24); end
    checks++; if (oovf4 !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", oovf4); end
    checks++; if (done4_cnt !== 1) begin errors++; $display("FAIL ovf_done_cnt: got %0d want 1", done4_cnt); end
    checks++; if (oovf[0] !== 1'b0) begin errors++; $display("FAIL ovf_wide_clear: got %b want 0", oovf[0]); end
    run_frame(3, 1, -1);
    checks++; if (oovf4 !== 1'b0) begin errors++; $display("FAIL ovf_fs_clear: got %b want 0", oovf4); end
  endtask

  task automatic test_reset_mid();
    cfg(1'b1, 0, 0, 0, 0, 0);
    cfg(1'b0, 0, 0, 8, 8, 0);
    fs = 1'b1; pv = 1'b1; ah = 11'd0; av = 10'd0; pd = 16'h0000;
    cycle();
    fs = 1'b0; ah = 11'd1; pd = 16'h0001;
    cycle();
    checks++; if (ov !== 1'b1) begin errors++; $display("FAIL rstmid_pre: got %b want 1", ov); end
    rst = 1'b1; ah = 11'd2; pd = 16'h0002;
    cycle();
    checks++; if (ov !== 1'b0) begin errors++; $display("FAIL rstmid_drop: got %b want 0", ov); end
    pv = 1'b0;
    cycle();
    rst = 1'b0;
    cycle();
    clear_log();
    run_frame(10, 9, -1);
    checks++; if (log_q.size() !== 0) begin errors++; $display("FAIL rstmid_silent: got %0d want 0", log_q.size()); end
    cfg(1'b0, 0, 0, 8, 8, 0);
    clear_log();
    run_frame(10, 9, -1);
    checks++; if (log_q.size() !== 64) begin errors++; $display("FAIL rstmid_recfg: got %0d want 64", log_q.size()); end
  endtask

  initial begin
    rst = 1'b1; fs = 1'b0; pv = 1'b0; ah = '0; av = '0; pd = '0;
    cfg_we = 1'b0; csel = 1'b0; cx0 = '0; cw = '0; cy0 = '0; ch = '0; cdec = '0;
    clear_log();
    test_reset();
    test_single();
    test_decimation();
    test_overlap();
    test_shadow();
    test_overflow();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
